// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame-buffer write path: command modes, writer states
// and the default virtual frame geometry used by both the writer and the VGA frame driver.
package frame_buf_pkg;

    localparam int VIRT_W_DEF = 160;
    localparam int VIRT_H_DEF = 120;
    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 24;

    // One bit wider than the 8-bit command coordinates so x+w cannot wrap.
    localparam int COORD_W = 9;

    typedef enum logic [1:0] {
        MODE_PIXEL = 2'b00,
        MODE_RECT  = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_RSVD  = 2'b11
    } cmd_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_GAP,
        ST_FINISH
    } wr_state_e;

    function automatic logic [COORD_W-1:0] min_coord(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rect_addr_gen.sv
// Row-major walker over a clipped rectangle: tracks the current column/row and the
// running row base address, and flags the final pixel of the rectangle.
module rect_addr_gen
    import frame_buf_pkg::*;
#(
    parameter int VIRT_W = VIRT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] x_end_i,
    input  logic [COORD_W-1:0] y_end_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               last_o
);

    logic [COORD_W-1:0] x_start_q;
    logic [COORD_W-1:0] x_end_q;
    logic [COORD_W-1:0] y_end_q;
    logic [COORD_W-1:0] cur_x_q;
    logic [COORD_W-1:0] cur_y_q;
    logic [ADDR_W-1:0]  row_base_q;
    logic               row_more;

    assign row_more = (cur_x_q + COORD_W'(1)) < x_end_q;
    assign last_o   = !row_more && ((cur_y_q + COORD_W'(1)) >= y_end_q);
    assign addr_o   = row_base_q + ADDR_W'(cur_x_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
        end else if (load_i) begin
            x_start_q  <= x_i;
            x_end_q    <= x_end_i;
            y_end_q    <= y_end_i;
            cur_x_q    <= x_i;
            cur_y_q    <= y_i;
            // The only multiply; afterwards rows advance by adding VIRT_W.
            row_base_q <= ADDR_W'(y_i) * ADDR_W'(VIRT_W);
        end else if (step_i) begin
            if (row_more) begin
                cur_x_q <= cur_x_q + COORD_W'(1);
            end else begin
                cur_x_q    <= x_start_q;
                cur_y_q    <= cur_y_q + COORD_W'(1);
                row_base_q <= row_base_q + ADDR_W'(VIRT_W);
            end
        end
    end

endmodule

// File: rtl/frame_buf_rect_writer.sv
// Command-driven pixel/rect/clear writer feeding the frame driver's write port with
// paced address/data/strobe triples.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | ready for a command
//   ST_SETUP  | resolve mode, clip rectangle, load the address walker
//   ST_WRITE  | issue one write (strobe appears on the next cycle)
//   ST_GAP    | pacing idle cycles between writes
//   ST_FINISH | raise done/err on the next cycle, then back to idle
module frame_buf_rect_writer
    import frame_buf_pkg::*;
#(
    parameter int VIRT_W = VIRT_W_DEF,
    parameter int VIRT_H = VIRT_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WR_GAP = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_mode_i,
    input  logic [7:0]        cmd_x_i,
    input  logic [7:0]        cmd_y_i,
    input  logic [7:0]        cmd_w_i,
    input  logic [7:0]        cmd_h_i,
    input  logic [DATA_W-1:0] cmd_color_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wr_en_o
);

    localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    wr_state_e          state_q, state_d;
    cmd_mode_e          mode_q;
    logic [7:0]         x_q, y_q, w_q, h_q;
    logic [DATA_W-1:0]  color_q;
    logic               err_flag_q, err_flag_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               busy_q, done_q, err_q, wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;

    logic               accept, issue, gen_load, gen_last;
    logic [ADDR_W-1:0]  gen_addr;
    logic [COORD_W-1:0] eff_x, eff_y, eff_w, eff_h, x_end, y_end;
    logic               setup_err, setup_empty;

    always_comb begin
        eff_x = {1'b0, x_q};
        eff_y = {1'b0, y_q};
        eff_w = {1'b0, w_q};
        eff_h = {1'b0, h_q};
        case (mode_q)
            MODE_PIXEL: begin
                eff_w = COORD_W'(1);
                eff_h = COORD_W'(1);
            end
            MODE_CLEAR: begin
                eff_x = '0;
                eff_y = '0;
                eff_w = COORD_W'(VIRT_W);
                eff_h = COORD_W'(VIRT_H);
            end
            default: ;
        endcase
    end

    assign x_end       = min_coord(eff_x + eff_w, COORD_W'(VIRT_W));
    assign y_end       = min_coord(eff_y + eff_h, COORD_W'(VIRT_H));
    assign setup_err   = (mode_q == MODE_RSVD) || (eff_x >= COORD_W'(VIRT_W))
                         || (eff_y >= COORD_W'(VIRT_H));
    assign setup_empty = (eff_w == '0) || (eff_h == '0);

    always_comb begin
        state_d    = state_q;
        err_flag_d = err_flag_q;
        gap_cnt_d  = gap_cnt_q;
        accept     = 1'b0;
        issue      = 1'b0;
        gen_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // busy_q lingers one cycle after FINISH so ready matches the registered view.
                if (cmd_valid_i && !busy_q) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                err_flag_d = setup_err;
                if (setup_err || setup_empty) begin
                    state_d = ST_FINISH;
                end else begin
                    gen_load = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort_i) begin
                    state_d = ST_FINISH;
                end else begin
                    issue = 1'b1;
                    if (gen_last) begin
                        state_d = ST_FINISH;
                    end else if (WR_GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    state_d = ST_FINISH;
                end else if (gap_cnt_q == '0) begin
                    state_d = ST_WRITE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_FINISH: begin
                err_flag_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rect_addr_gen #(
        .VIRT_W (VIRT_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (gen_load),
        .step_i  (issue),
        .x_i     (eff_x),
        .y_i     (eff_y),
        .x_end_i (x_end),
        .y_end_i (y_end),
        .addr_o  (gen_addr),
        .last_o  (gen_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_PIXEL;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            err_flag_q <= 1'b0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_flag_q <= err_flag_d;
            gap_cnt_q  <= gap_cnt_d;
            if (accept) begin
                mode_q  <= cmd_mode_e'(cmd_mode_i);
                x_q     <= cmd_x_i;
                y_q     <= cmd_y_i;
                w_q     <= cmd_w_i;
                h_q     <= cmd_h_i;
                color_q <= cmd_color_i;
            end
            busy_q  <= (state_d != ST_IDLE) || (state_q == ST_FINISH);
            done_q  <= (state_q == ST_FINISH);
            err_q   <= (state_q == ST_FINISH) && err_flag_q;
            wr_en_q <= issue;
            if (issue) begin
                wr_addr_q <= gen_addr;
                wr_data_q <= color_q;
            end
        end
    end

    assign cmd_ready_o = !busy_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_frame_buf_rect_writer.sv
// Self-checking bench for frame_buf_rect_writer: directed scenarios plus random
// commands, compared against a list-of-addresses reference model.
module tb_frame_buf_rect_writer;

    localparam int VW     = 160;
    localparam int VH     = 120;
    localparam int AW     = 15;
    localparam int DW     = 24;
    localparam int TB_GAP = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready_o;
    logic [1:0]    cmd_mode;
    logic [7:0]    cmd_x, cmd_y, cmd_w, cmd_h;
    logic [DW-1:0] cmd_color;
    logic          abort;
    logic          busy_o, done_o, err_o, wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    bit exp_err;

    always #5 clk = ~clk;

    frame_buf_rect_writer #(
        .VIRT_W (VW),
        .VIRT_H (VH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .WR_GAP (TB_GAP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_mode_i  (cmd_mode),
        .cmd_x_i     (cmd_x),
        .cmd_y_i     (cmd_y),
        .cmd_w_i     (cmd_w),
        .cmd_h_i     (cmd_h),
        .cmd_color_i (cmd_color),
        .abort_i     (abort),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_en_o     (wr_en_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of addresses a command should touch, in row-major order.
    task automatic build_expect(input logic [1:0] m, input int x, input int y,
                                input int w, input int h);
        int x0, y0, w0, h0, xe, ye;
        exp_q.delete();
        exp_err = 1'b0;
        x0 = x; y0 = y; w0 = w; h0 = h;
        if (m == 2'b00) begin w0 = 1; h0 = 1; end
        if (m == 2'b10) begin x0 = 0; y0 = 0; w0 = VW; h0 = VH; end
        if (m == 2'b11 || x0 >= VW || y0 >= VH) begin
            exp_err = 1'b1;
            return;
        end
        xe = (x0 + w0 < VW) ? x0 + w0 : VW;
        ye = (y0 + h0 < VH) ? y0 + h0 : VH;
        for (int yy = y0; yy < ye; yy++)
            for (int xx = x0; xx < xe; xx++)
                exp_q.push_back(yy * VW + xx);
    endtask

    task automatic run_cmd(input logic [1:0] m, input int x, input int y, input int w,
                           input int h, input logic [DW-1:0] col, input int abort_after,
                           input bit hold_valid, input string tag);
        int  n, last_cyc, dcyc, wait_c, exp_n, bound;
        bit  got_done, aborting;
        build_expect(m, x, y, w, h);
        exp_n    = exp_q.size();
        aborting = (abort_after > 0) && (abort_after < exp_n);
        if (aborting) exp_n = abort_after;
        wait_c = 0;
        while (!cmd_ready_o && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        check({tag, "/ready_in"}, cmd_ready_o, 1);
        cmd_mode  = m;
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = col;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) begin
            cmd_mode  = 2'($urandom);
            cmd_x     = 8'($urandom);
            cmd_y     = 8'($urandom);
            cmd_w     = 8'($urandom);
            cmd_h     = 8'($urandom);
            cmd_color = DW'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        check({tag, "/busy"}, busy_o, 1);
        n = 0; last_cyc = -1; dcyc = -1; got_done = 1'b0;
        bound = 40 + exp_q.size() * (1 + TB_GAP);
        for (int cyc = 0; cyc < bound; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (wr_en_o) begin
                if (n < exp_n) begin
                    check({tag, "/addr"}, wr_addr_o, exp_q[n]);
                    check({tag, "/data"}, wr_data_o, col);
                end
                if (n == 0) check({tag, "/first_cyc"}, cyc, 2);
                else        check({tag, "/spacing"}, cyc - last_cyc, 1 + TB_GAP);
                last_cyc = cyc;
                n++;
                if (abort_after > 0 && n == abort_after) abort = 1'b1;
            end
            if (done_o) begin
                got_done = 1'b1;
                dcyc = cyc;
                break;
            end
            if (err_o) check({tag, "/err_early"}, err_o, 0);
        end
        check({tag, "/done_seen"}, got_done, 1);
        check({tag, "/writes"}, n, exp_n);
        check({tag, "/err"}, err_o, exp_err);
        if (!aborting) check({tag, "/done_cyc"}, dcyc, (exp_n > 0) ? last_cyc + 1 : 2);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        check({tag, "/ready_out"}, cmd_ready_o, 1);
        check({tag, "/idle_busy"}, busy_o, 0);
        check({tag, "/done_pulse"}, done_o, 0);
        check({tag, "/idle_wr_en"}, wr_en_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready"}, cmd_ready_o, 1);
        check({tag, "/busy"}, busy_o, 0);
        check({tag, "/done"}, done_o, 0);
        check({tag, "/err"}, err_o, 0);
        check({tag, "/wr_en"}, wr_en_o, 0);
        check({tag, "/addr"}, wr_addr_o, 0);
        check({tag, "/data"}, wr_data_o, 0);
    endtask

    initial begin
        int cnt, idle_wr;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00;
        cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd0; cmd_h = 8'd0;
        cmd_color = '0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // abort while idle must do nothing
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle/busy", busy_o, 0);
        check("abort_idle/done", done_o, 0);
        check("abort_idle/wr_en", wr_en_o, 0);
        abort = 1'b0;

        run_cmd(2'b00, 5, 2, 0, 0, 24'hFF00FF, 0, 1'b0, "pixel");
        run_cmd(2'b01, 158, 0, 4, 2, 24'h123456, 0, 1'b1, "rect_clip");
        run_cmd(2'b11, 3, 3, 2, 2, 24'h00AA00, 0, 1'b0, "rsvd");
        run_cmd(2'b01, 200, 5, 4, 4, 24'h0000AA, 0, 1'b0, "offscreen_x");
        run_cmd(2'b01, 10, 130, 4, 4, 24'h0000BB, 0, 1'b0, "offscreen_y");
        run_cmd(2'b01, 10, 10, 0, 5, 24'h0000CC, 0, 1'b0, "zero_w");
        run_cmd(2'b01, 10, 10, 5, 0, 24'h0000DD, 0, 1'b0, "zero_h");
        run_cmd(2'b01, 20, 30, 10, 10, 24'hC0FFEE, 3, 1'b0, "abort3");
        run_cmd(2'b01, 150, 115, 20, 20, 24'hBEEF01, 0, 1'b0, "rect_corner");
        run_cmd(2'b10, 7, 7, 7, 7, 24'h0A0B0C, 0, 1'b0, "clear");

        // reset in the middle of a clear
        cmd_mode = 2'b10; cmd_color = 24'h777777; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3000 && cnt < 500; c++) begin
            @(negedge clk);
            if (wr_en_o) cnt++;
        end
        check("midclear/progress", cnt, 500);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midclear_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle_wr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wr_en_o) idle_wr++;
        end
        check("midclear/no_writes", idle_wr, 0);
        run_cmd(2'b00, 5, 2, 0, 0, 24'hFF00FF, 0, 1'b0, "pixel_after_rst");

        for (int i = 0; i < 30; i++) begin
            int r;
            logic [1:0] m;
            r = $urandom_range(0, 9);
            m = (r < 2) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11;
            run_cmd(m, $urandom_range(0, 175), $urandom_range(0, 128),
                    $urandom_range(0, 12), $urandom_range(0, 6), DW'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                    1'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_buf_rect_writer.md
# frame_buf_rect_writer

Command-driven pixel writer that sits between control logic (key/switch handling or a game FSM) and the VGA frame driver's frame-buffer write port. It accepts single-pixel, clipped rectangle-fill and full-screen-clear commands over a valid/ready handshake. It converts each command into a paced stream of address/data/write-strobe triples on the frame driver's write interface. It is parametrised in virtual resolution, colour width and write pacing.

## Interface
- VIRT_W, 160: virtual frame width in memory words per row
- VIRT_H, 120: virtual frame height in rows
- ADDR_W, 15: frame-buffer address width; must satisfy 2^ADDR_W >= VIRT_W*VIRT_H
- DATA_W, 24: colour word width
- WR_GAP, 1: idle cycles inserted after every write strobe (0 = back-to-back)
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_mode  in  2  00 pixel, 01 rect fill, 10 clear, 11 reserved
- cmd_x, cmd_y  in  8 each  top-left virtual coordinate
- cmd_w, cmd_h  in  8 each  rect size in virtual pixels (ignored for pixel/clear)
- cmd_color  in  DATA_W  fill colour
- abort  in  1  stop current command after the in-flight write
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on command completion
- err  out  1  one-cycle pulse, coincident with done, for reserved mode or fully off-screen origin
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  DATA_W  frame-buffer write data
- wr_en  out  1  one-cycle write strobe

## Operation
- States: IDLE, SETUP, WRITE, GAP, FINISH.
- IDLE: cmd_ready=1. When cmd_valid && cmd_ready are high at a rising edge, latch all cmd_* fields and go to SETUP.
- SETUP computes the effective rectangle:
  - pixel: w=h=1.
  - clear: x=y=0, w=VIRT_W, h=VIRT_H.
  - rect: clip to x_end=min(x+w, VIRT_W), y_end=min(y+h, VIRT_H).
  - Coordinate arithmetic is 9 bits wide so that x+w does not overflow.
  - Reserved mode, x>=VIRT_W, or y>=VIRT_H: go to FINISH with err.
  - w=0 or h=0: go to FINISH with no writes and no err.
  - Otherwise load row_base=y*VIRT_W, one multiply per command, and go to WRITE.
- WRITE: drive wr_addr=row_base+cur_x, wr_data=color, wr_en=1 for exactly one cycle. Then step:
  - cur_x+1 while cur_x+1 < x_end.
  - Otherwise reset cur_x to x, add VIRT_W to row_base, and increment cur_y.
  - After the write at (x_end-1, y_end-1), go to FINISH.
  - Otherwise go to GAP if WR_GAP>0, else stay in WRITE.
- GAP: hold WR_GAP cycles with wr_en=0, then return to WRITE.
- Write order is row-major, left to right, top to bottom.
- FINISH: pulse done (and err when flagged) for one cycle, then go to IDLE.
- abort: sampled in WRITE and GAP. The write strobed in the same cycle completes; no further writes are issued. Then go to FINISH with done=1 and err=0. abort in IDLE is ignored.
- busy=1 in every state except IDLE; cmd_ready equals !busy.
- cmd_valid while busy is not accepted and has no effect.

## Timing
- Reset (asynchronous, any state, including mid-fill): state=IDLE, cmd_ready=1, busy=0, done=0, err=0, wr_en=0, wr_addr=0, wr_data=0, all counters 0. No partial write strobe is emitted after reset is asserted.
- All outputs are registered.
- Accept edge T: SETUP during T..T+1, first wr_en high in cycle T+2.
- Write throughput: one strobe per (1+WR_GAP) cycles.
- done is asserted the cycle after the last wr_en.
- Pixel command latency: wr_en in cycle T+2, done in T+3, cmd_ready back high in T+4.
- A new command may be accepted on the first cycle cmd_ready is high again.
- wr_addr and wr_data are valid only while wr_en=1. Between strobes they hold their last values.
- Clear writes VIRT_W*VIRT_H words, with the last address VIRT_W*VIRT_H-1.

## Structure
- Shared package frame_buf_pkg holds:
  - mode encodings MODE_PIXEL/MODE_RECT/MODE_CLEAR/MODE_RSVD
  - the state enum
  - default VIRT_W/VIRT_H/ADDR_W/DATA_W constants, shared with the frame driver
- Sub-module rect_addr_gen holds the cur_x/cur_y/row_base stepping and the last-pixel detect. The top module holds the FSM, handshake and pacing.

## Test plan
- Pixel (5,2), colour 24'hFF00FF, WR_GAP=0 -> a single wr_en with wr_addr=325 and wr_data=FF00FF; done one cycle later; err=0.
- Rect x=158, y=0, w=4, h=2 -> exactly 4 writes at addresses 158, 159, 318, 319 (clipped); done pulse.
- Clear with WR_GAP=1 -> 19200 writes at addresses 0..19199 in order, strobes every 2nd cycle; done after the last.
- Reserved mode, then rect with x=200 -> zero writes; done and err pulse together each time; w=0 -> done without err.
- Rect 10x10 with abort raised after the 3rd strobe -> exactly 3 writes (3rd completes), then done; cmd_ready high 1 cycle later.
- Reset asserted mid-clear -> wr_en drops immediately, outputs at reset values; after release, the next pixel command behaves as in scenario 1.
